// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I main controller.
package mc_pkg;

  // Controller states; 4-bit encoding leaves five codes unused.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Supported opcodes (instr[6:0]).
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp handed to the ALU decoder.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Result mux select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format select.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format decoder: selects the extender format from the opcode alone.
module imm_src_dec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  // Opcode to immediate format; unknown opcodes fall back to I-type.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    imm_src = IMM_I;
    case (op)
      OP_LW,
      OP_I:    imm_src = IMM_I;
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with a mem_ready handshake stalling memory states.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_instr,
  output logic       instr_done
);

  state_t state_q, state_d;

  // Raw enables before reset gating.
  logic pc_write_r, mem_write_r, ir_write_r, reg_write_r;
  logic illegal_r, done_r;

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state decode; op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB,
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode from state plus the mem_ready/zero/op qualifiers.
  always_comb begin
    pc_write_r  = 1'b0;
    mem_write_r = 1'b0;
    ir_write_r  = 1'b0;
    reg_write_r = 1'b0;
    illegal_r   = 1'b0;
    done_r      = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        result_src = RES_ALURESULT;
        alu_src_b  = SRCB_FOUR;
        ir_write_r = mem_ready;
        pc_write_r = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_r = 1'b0;
          default:                                  illegal_r = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_r = 1'b1;
        done_r      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_r = 1'b1;
        done_r      = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_r = 1'b1;
        done_r      = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_SUB;
        pc_write_r = zero;
        done_r     = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_r = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are held off while reset is asserted; selects already show
  // FETCH values because the state register is forced to FETCH.
  assign pc_write      = pc_write_r  & rst_n;
  assign mem_write     = mem_write_r & rst_n;
  assign ir_write      = ir_write_r  & rst_n;
  assign reg_write     = reg_write_r & rst_n;
  assign illegal_instr = illegal_r   & rst_n;
  assign instr_done    = done_r      & rst_n;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller for the RV32I subset core: lw, sw, R-type, I-type ALU, beq, jal. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write enable in the shared-memory multicycle datapath, and produces the 2-bit ALUOp consumed by the downstream ALU decoder. A memory handshake (mem_ready) stalls the sequence on variable-latency memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  0 = PC, 1 = ALU result register as memory address
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction and old-PC register enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- alu_src_b  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- instr_done  out  1  one-cycle pulse in the last state of each instruction

## Operation
- Opcodes: LW 0000011, SW 0100011, R 0110011, I 0010011, BEQ 1100011, JAL 1101111.
- States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH → DECODE when mem_ready; otherwise hold FETCH.
  - DECODE → MEMADR for LW or SW.
  - DECODE → EXECR / EXECI / BEQ / JAL for R / I / BEQ / JAL.
  - DECODE → FETCH for any other opcode, with illegal_instr = 1 that cycle.
  - MEMADR → MEMREAD for LW, MEMWRITE for SW.
  - MEMREAD → MEMWB when mem_ready; otherwise hold.
  - MEMWB → FETCH.
  - MEMWRITE → FETCH when mem_ready; otherwise hold.
  - EXECR → ALUWB; EXECI → ALUWB; JAL → ALUWB.
  - ALUWB → FETCH; BEQ → FETCH.
- Outputs per state (unlisted outputs are 0; every select defaults to 00, never x):
  - FETCH: adr_src 0; alu_src_a 00; alu_src_b 10; alu_op 00; result_src 10; ir_write = mem_ready; pc_write = mem_ready.
  - DECODE: alu_src_a 01; alu_src_b 01; alu_op 00 (branch target).
  - MEMADR: alu_src_a 10; alu_src_b 01; alu_op 00.
  - MEMREAD: adr_src 1; result_src 00.
  - MEMWB: result_src 01; reg_write 1.
  - MEMWRITE: adr_src 1; result_src 00; mem_write held 1 until mem_ready.
  - EXECR: alu_src_a 10; alu_src_b 00; alu_op 10.
  - EXECI: alu_src_a 10; alu_src_b 01; alu_op 10.
  - ALUWB: result_src 00; reg_write 1.
  - BEQ: alu_src_a 10; alu_src_b 00; alu_op 01; result_src 00; pc_write = zero.
  - JAL: alu_src_a 01; alu_src_b 10; alu_op 00; result_src 00; pc_write 1.
- imm_src is purely combinational from op in all states: LW/I → 00, SW → 01, BEQ → 10, JAL → 11, other → 00.
- instr_done = 1 in:
  - MEMWB and ALUWB;
  - BEQ;
  - MEMWRITE when mem_ready.

## Timing
- The state register is the only storage. It resets asynchronously to FETCH.
- While rst_n = 0: pc_write, ir_write, mem_write, reg_write, illegal_instr and instr_done are forced to 0. Selects show FETCH values: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10.
- Reset asserted mid-instruction aborts it. The next cycle after release is FETCH; no partial write-back occurs.
- Outputs are combinational from state, op, zero and mem_ready. There is no output register.
- Latency with mem_ready tied 1:
  - beq: 3 cycles.
  - R, I, jal, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle of mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Enables stay deasserted during the stall, except mem_write, which stays asserted.
- In FETCH, pc_write and ir_write assert in the same single cycle in which mem_ready = 1. The PC therefore advances exactly once per fetch.
- op is sampled only in DECODE and MEMADR. The IR is stable from DECODE until the next FETCH completes.

## Structure
- Shared package mc_pkg holds:
  - state enum (4-bit);
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - encodings for alu_op, result_src, alu_src_a/b and imm_src.
- One sub-module, imm_src_dec: combinational op → imm_src.
- The FSM next-state and output decode stay in mc_controller.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with mem_ready = 1 → all enables 0 and state FETCH. After release, the first cycle shows pc_write = ir_write = 1.
- add (op = 0110011), mem_ready = 1 → FETCH, DECODE, EXECR (alu_op 10, alu_src_b 00), ALUWB (reg_write 1, instr_done 1), then FETCH. 4 cycles total.
- lw, with mem_ready = 0 for 2 cycles in MEMREAD → 7 cycles total. In MEMWB, result_src = 01 and reg_write = 1. reg_write is never 1 before MEMWB.
- sw, with mem_ready low for 1 cycle in MEMWRITE → mem_write high for 2 consecutive cycles with adr_src = 1. instr_done pulses only on the second cycle.
- beq run twice, zero = 1 then zero = 0 → pc_write = 1 in BEQ only on the first. Each run lasts 3 cycles.
- Illegal op 1111111 → illegal_instr pulses in DECODE, the next state is FETCH, and no reg_write or mem_write is seen. Asserting rst_n low during EXECI returns to FETCH with reg_write never asserted.
